// File: rtl/risc16_mc_core.sv
// risc16_mc_core: multi-cycle RiSC-16 core (8 opcodes, 16-bit instructions)
// with a DATA_W-wide datapath, a req/ack memory port that tolerates wait
// states, and a terminal HALT state.
// Optional feature macro: RISC16_PERF_EN builds the retired-instruction
// counter behind instret; without it instret is tied to zero.
module risc16_mc_core #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 16,
    parameter int PROG_START = 'h00FF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [PC_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [31:0]       instret
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0, OP_ADDI = 3'd1, OP_NAND = 3'd2, OP_LUI  = 3'd3,
                           OP_SW   = 3'd4, OP_LW   = 3'd5, OP_BEQ  = 3'd6, OP_JALR = 3'd7;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc, pc_d, addr_d;
    logic [15:0]       ir, ir_d;
    logic              req_d, we_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] gpr [8];

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // instruction fields
    logic [2:0]        op, ra, rb, rc;
    logic [6:0]        imm7;
    logic [DATA_W-1:0] ra_val, rb_val, rc_val, simm_d;
    logic [PC_W-1:0]   pc_inc, simm_p, br_tgt, eff_addr;

    assign op     = ir[15:13];
    assign ra     = ir[12:10];
    assign rb     = ir[9:7];
    assign rc     = ir[2:0];
    assign imm7   = ir[6:0];
    // r0 is never written, so it reads back as its reset value of zero
    assign ra_val = gpr[ra];
    assign rb_val = gpr[rb];
    assign rc_val = gpr[rc];
    assign simm_d = {{(DATA_W-7){imm7[6]}}, imm7};
    assign simm_p = {{(PC_W-7){imm7[6]}}, imm7};
    assign pc_inc = pc + 1'b1;
    assign br_tgt = pc_inc + simm_p;
    assign eff_addr = PC_W'(rb_val + simm_d);

    assign halted = (state == S_HALT);

    // next state, next bus request and register write for the current state
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state)
            S_FETCH: begin
                if (!mem_req) begin
                    // first fetch after reset: raise the request
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc;
                end else if (mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD:  begin wr_en = 1'b1; wr_data = rb_val + rc_val;    end
                    OP_ADDI: begin wr_en = 1'b1; wr_data = rb_val + simm_d;    end
                    OP_NAND: begin wr_en = 1'b1; wr_data = ~(rb_val & rc_val); end
                    OP_LUI:  begin wr_en = 1'b1; wr_data = {ir[9:0], {(DATA_W-10){1'b0}}}; end
                    OP_SW, OP_LW: begin
                        state_d = S_MEM;
                        pc_d    = pc;
                    end
                    OP_BEQ:  if (ra_val == rb_val) pc_d = br_tgt;
                    OP_JALR: begin
                        if (imm7 == 7'd0) begin
                            // link uses the pre-jump pc, target is rB read before the write
                            wr_en   = 1'b1;
                            wr_data = DATA_W'(pc_inc);
                            pc_d    = rb_val[PC_W-1:0];
                        end else begin
                            state_d = S_HALT;
                            pc_d    = pc;
                        end
                    end
                    default: ;
                endcase
                // every EXEC exit except HALT starts a bus transaction right away
                if (state_d == S_FETCH) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_d;
                end else if (state_d == S_MEM) begin
                    req_d   = 1'b1;
                    we_d    = (op == OP_SW);
                    addr_d  = eff_addr;
                    wdata_d = ra_val;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (!mem_we) begin
                        wr_en   = 1'b1;
                        wr_data = mem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_inc;
                end
            end
            S_HALT: req_d = 1'b0;
            default: state_d = S_FETCH;
        endcase
    end

    // architectural state, registered bus outputs and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= PC_W'(PROG_START);
            ir        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 8; i++) gpr[i] <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            if (wr_en && ra != 3'd0) gpr[ra] <= wr_data;
        end
    end

`ifdef RISC16_PERF_EN
    logic [31:0] instret_q;
    logic        retire;
    // EXEC->FETCH covers every non-memory op; HALT never reaches FETCH
    assign retire = (state == S_EXEC && state_d == S_FETCH) || (state == S_MEM && mem_ack);

    // retired-instruction counter, wraps at 2^32
    always_ff @(posedge clk) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_risc16_mc_core.sv
// Directed bench for risc16_mc_core: a DATA_W=16 core on a wait-state
// memory model plus a DATA_W=32 core on a zero-wait memory.
module tb_risc16_mc_core;

`ifdef RISC16_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1, rst32 = 1'b1;
    logic        mem_req, mem_we, mem_ack = 1'b0, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [31:0] instret;
    logic        m32_req, m32_we, m32_ack = 1'b0, halted32;
    logic [15:0] m32_addr;
    logic [31:0] m32_wdata, m32_rdata = '0, instret32;

    logic [15:0] mem   [1024] = '{default: 16'h0};
    logic [15:0] mem32 [1024] = '{default: 16'h0};
    int          nwait = 0, wcnt = 0;
    logic        ld_en = 1'b0, ld_sel = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    int tot_cnt = 0, fail_cnt = 0;

    always #5 clk = ~clk;

    risc16_mc_core #(.DATA_W(16), .PC_W(16), .PROG_START('h00FF)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .instret(instret));

    risc16_mc_core #(.DATA_W(32), .PC_W(16), .PROG_START('h00FF)) dut32 (
        .clk(clk), .rst(rst32), .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr),
        .mem_wdata(m32_wdata), .mem_rdata(m32_rdata), .mem_ack(m32_ack),
        .halted(halted32), .instret(instret32));

    // memory models: respond between clock edges, nwait idle cycles before ack
    always @(negedge clk) begin
        if (ld_en) begin
            if (ld_sel) mem32[ld_addr] = ld_data;
            else        mem[ld_addr]   = ld_data;
        end
        if (mem_req) begin
            if (wcnt >= nwait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[9:0]];
                if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        m32_ack   = m32_req;
        m32_rdata = {16'h0, mem32[m32_addr[9:0]]};
    end

    function automatic logic [15:0] rri(int op, int a, int b, int imm);
        return 16'((op << 13) | (a << 10) | (b << 7) | (imm & 'h7F));
    endfunction
    function automatic logic [15:0] lui(int a, int imm10);
        return 16'((3 << 13) | (a << 10) | (imm10 & 'h3FF));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load(input bit to32, input int a, input logic [15:0] d);
        ld_sel = to32; ld_addr = a[9:0]; ld_data = d; ld_en = 1'b1;
        @(negedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic run_until_pc(input string tag, input logic [15:0] tgt, input int budget,
                                output int cyc);
        cyc = 0;
        do begin step(1); cyc++; end while (dut.pc !== tgt && cyc < budget);
        check(tag, dut.pc, tgt);
    endtask

    initial begin
        int cyc;
        // program: arithmetic, store/load, LUI/JALR into 0x120, JALR to 0x200, branches
        load(0, 'h0FF, rri(1, 1, 0, 5));      // ADDI r1,r0,5
        load(0, 'h100, rri(1, 2, 0, -3));     // ADDI r2,r0,-3
        load(0, 'h101, rri(0, 3, 1, 2));      // ADD  r3,r1,r2
        load(0, 'h102, rri(4, 3, 0, 10));     // SW   r3,[r0+10]
        load(0, 'h103, rri(5, 4, 0, 10));     // LW   r4,[r0+10]
        load(0, 'h104, lui(7, 4));            // r7 = 0x100
        load(0, 'h105, rri(1, 7, 7, 32));     // r7 = 0x120
        load(0, 'h106, lui(6, 8));            // r6 = 0x200
        load(0, 'h107, rri(7, 0, 7, 0));      // JALR r0,r7 (link dropped)
        load(0, 'h120, rri(7, 5, 6, 0));      // JALR r5,r6
        load(0, 'h200, rri(6, 1, 2, 4));      // BEQ r1,r2,+4 (not taken)
        load(0, 'h201, rri(6, 1, 1, -1));     // BEQ r1,r1,-1 (self loop)
        load(1, 'h0FF, rri(1, 1, 0, 5));
        load(1, 'h100, rri(1, 2, 0, -3));
        load(1, 'h101, rri(0, 3, 1, 2));

        step(2);
        check("rst_req", mem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", dut.pc, 16'h00FF);
        check("rst_instret", instret, 0);
        rst = 1'b0;
        step(1);
        check("first_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h00FF});
        check("first_halted", halted, 0);

        run_until_pc("pc_100", 16'h0100, 10, cyc);
        check("lat_addi1", cyc, 2);
        run_until_pc("pc_101", 16'h0101, 10, cyc);
        check("lat_addi2", cyc, 2);
        run_until_pc("pc_102", 16'h0102, 10, cyc);
        check("lat_add", cyc, 2);
        check("r1", dut.gpr[1], 16'h0005);
        check("r2", dut.gpr[2], 16'hFFFD);
        check("r3", dut.gpr[3], 16'h0002);
        check("instret_3", instret, PERF ? 3 : 0);

        nwait = 2;
        cyc = 0;
        do begin step(1); cyc++; end while (!(mem_req && mem_we) && cyc < 20);
        check("sw_req", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'd10, 16'd2});
        step(1);
        check("sw_hold1", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'd10, 16'd2});
        step(1);
        check("sw_hold2", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'd10, 16'd2});
        run_until_pc("pc_103", 16'h0103, 5, cyc);
        check("sw_done_lat", cyc, 1);
        check("mem10", mem[10], 16'd2);

        cyc = 0;
        do begin step(1); cyc++; end while (!(mem_req && !mem_we && mem_addr == 16'd10) && cyc < 20);
        check("lw_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'd10});
        step(1);
        check("lw_hold1", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'd10});
        step(1);
        check("lw_hold2", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'd10});
        run_until_pc("pc_104", 16'h0104, 5, cyc);
        check("r4", dut.gpr[4], 16'd2);
        nwait = 0;

        run_until_pc("pc_120", 16'h0120, 30, cyc);
        check("r7_lui_addi", dut.gpr[7], 16'h0120);
        check("r6_lui", dut.gpr[6], 16'h0200);
        check("r0_zero", dut.gpr[0], 16'h0000);
        run_until_pc("pc_200", 16'h0200, 10, cyc);
        check("lat_jalr", cyc, 2);
        check("r5_link", dut.gpr[5], 16'h0121);
        run_until_pc("pc_201", 16'h0201, 10, cyc);
        check("lat_beq_nt", cyc, 2);

        step(6);
        check("beq_loop_pc", dut.pc, 16'h0201);
        check("beq_loop_fetch", {mem_req, mem_addr}, {1'b1, 16'h0201});
        check("instret_loop", instret, PERF ? 14 : 0);

        load(0, 'h201, rri(7, 0, 0, 1));      // JALR imm7=1 -> HALT
        cyc = 0;
        do begin step(1); cyc++; end while (!halted && cyc < 10);
        check("halted", halted, 1);
        check("halt_req", mem_req, 0);
        check("halt_pc", dut.pc, 16'h0201);
        step(5);
        check("halt_stay", {halted, mem_req}, {1'b1, 1'b0});
        check("halt_instret", instret, PERF ? 14 : 0);

        // reset in the middle of a waiting store
        load(0, 'h0FF, rri(1, 1, 0, 7));      // ADDI r1,r0,7
        load(0, 'h100, rri(4, 1, 0, 10));     // SW r1,[r0+10]
        nwait = 4;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        cyc = 0;
        do begin step(1); cyc++; end while (!(mem_req && mem_we) && cyc < 40);
        check("b_sw_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 16'd10});
        check("b_r1", dut.gpr[1], 16'd7);
        step(1);
        rst = 1'b1;
        step(1);
        check("midrst_req", {mem_req, mem_we}, 2'b00);
        check("midrst_pc", dut.pc, 16'h00FF);
        check("midrst_r1", dut.gpr[1], 16'd0);
        check("midrst_instret", instret, 0);
        step(6);
        check("midrst_dropped", mem[10], 16'd2);
        rst = 1'b0;

        // DATA_W=32 rerun of the arithmetic sequence
        rst32 = 1'b0;
        cyc = 0;
        do begin step(1); cyc++; end while (dut32.pc !== 16'h0102 && cyc < 20);
        check("w32_lat", cyc, 7);
        check("w32_r2", dut32.gpr[2], 32'hFFFF_FFFD);
        check("w32_r3", dut32.gpr[3], 32'd2);
        check("w32_instret", instret32, PERF ? 3 : 0);

        $display("%0d/%0d checks passed", tot_cnt - fail_cnt, tot_cnt);
        $finish;
    end

endmodule
